// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Each requester owns a one-deep result slot; results are registered with 1-cycle latency.
module alu_share_arb #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned MAX_ALUOP  = 9
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_op1_i,
  input  logic [31:0] req0_op2_i,
  input  logic [5:0]  req0_aluop_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_op1_i,
  input  logic [31:0] req1_op2_i,
  input  logic [5:0]  req1_aluop_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_result_o,
  output logic        rsp0_err_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_result_o,
  output logic        rsp1_err_o,
  output logic [31:0] alu_op1_o,
  output logic [31:0] alu_op2_o,
  output logic [5:0]  alu_aluop_o,
  input  logic [31:0] alu_result_i
);

  localparam logic [5:0] MAX_OP_C = 6'(MAX_ALUOP);

  logic [1:0]  full_q, full_d;
  logic [31:0] res_q [2];
  logic [31:0] res_d [2];
  logic [1:0]  err_q, err_d;
  logic        ptr_q, ptr_d;

  logic [1:0]  free_s, elig_s, gnt_s, rsp_rdy_s;
  logic        illegal_s;
  logic [31:0] cap_res_s;

  // Eligibility and grant: ready never depends on operands, only on valids, rsp ready and state.
  always_comb begin
    rsp_rdy_s = {rsp1_ready_i, rsp0_ready_i};
    free_s    = ~full_q | rsp_rdy_s;
    elig_s    = {req1_valid_i, req0_valid_i} & free_s & {2{rst_ni}};
    case (elig_s)
      2'b01:   gnt_s = 2'b01;
      2'b10:   gnt_s = 2'b10;
      2'b11: begin
        if (FIXED_PRIO != 0) begin
          gnt_s = 2'b01;
        end else begin
          gnt_s = ptr_q ? 2'b10 : 2'b01;
        end
      end
      default: gnt_s = 2'b00;
    endcase
  end

  assign req0_ready_o = gnt_s[0];
  assign req1_ready_o = gnt_s[1];

  // Shared ALU port mux: zeros when idle.
  always_comb begin
    case (gnt_s)
      2'b01: begin
        alu_op1_o   = req0_op1_i;
        alu_op2_o   = req0_op2_i;
        alu_aluop_o = req0_aluop_i;
      end
      2'b10: begin
        alu_op1_o   = req1_op1_i;
        alu_op2_o   = req1_op2_i;
        alu_aluop_o = req1_aluop_i;
      end
      default: begin
        alu_op1_o   = 32'd0;
        alu_op2_o   = 32'd0;
        alu_aluop_o = 6'd0;
      end
    endcase
    illegal_s = (alu_aluop_o > MAX_OP_C);
    cap_res_s = illegal_s ? 32'd0 : alu_result_i;
  end

  // Slot and pointer next state; a draining slot clears so EMPTY slots always read as zero.
  always_comb begin
    full_d = full_q;
    err_d  = err_q;
    ptr_d  = ptr_q;
    for (int n = 0; n < 2; n++) begin
      res_d[n] = res_q[n];
      if (gnt_s[n]) begin
        full_d[n] = 1'b1;
        res_d[n]  = cap_res_s;
        err_d[n]  = illegal_s;
      end else if (full_q[n] && rsp_rdy_s[n]) begin
        full_d[n] = 1'b0;
        res_d[n]  = 32'd0;
        err_d[n]  = 1'b0;
      end else begin
        full_d[n] = full_q[n];
      end
    end
    if ((FIXED_PRIO == 0) && (gnt_s != 2'b00)) begin
      ptr_d = gnt_s[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q   <= 2'b00;
      res_q[0] <= 32'd0;
      res_q[1] <= 32'd0;
      err_q    <= 2'b00;
      ptr_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      res_q[0] <= res_d[0];
      res_q[1] <= res_d[1];
      err_q    <= err_d;
      ptr_q    <= ptr_d;
    end
  end

  assign rsp0_valid_o  = full_q[0];
  assign rsp1_valid_o  = full_q[1];
  assign rsp0_result_o = res_q[0];
  assign rsp1_result_o = res_q[1];
  assign rsp0_err_o    = err_q[0];
  assign rsp1_err_o    = err_q[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a round-robin and a fixed-priority instance share stimulus,
// checked each cycle against a slot/queue-level reference model plus directed constants.
module tb_alu_share_arb;

  localparam int MAXOP = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v0, v1, rr0, rr1;
  logic [31:0] a0, b0, a1, b1;
  logic [5:0]  op0, op1;

  logic [1:0]  rdy0, rdy1, rv0, rv1, re0, re1;
  logic [31:0] rres0 [2];
  logic [31:0] rres1 [2];
  logic [31:0] ao1 [2];
  logic [31:0] ao2 [2];
  logic [31:0] ares [2];
  logic [5:0]  aop [2];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      6'd0: return x + y;
      6'd1: return x - y;
      6'd2: return x & y;
      6'd3: return x | y;
      6'd4: return x ^ y;
      6'd5: return x << y[4:0];
      6'd6: return x >> y[4:0];
      6'd7: return $signed(x) >>> y[4:0];
      6'd8: return {31'd0, $signed(x) < $signed(y)};
      6'd9: return {31'd0, x < y};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign ares[0] = alu_ref(aop[0], ao1[0], ao2[0]);
  assign ares[1] = alu_ref(aop[1], ao1[1], ao2[1]);

  alu_share_arb #(.FIXED_PRIO(0), .MAX_ALUOP(MAXOP)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_ready_o(rdy0[0]), .req0_op1_i(a0), .req0_op2_i(b0), .req0_aluop_i(op0),
    .req1_valid_i(v1), .req1_ready_o(rdy1[0]), .req1_op1_i(a1), .req1_op2_i(b1), .req1_aluop_i(op1),
    .rsp0_valid_o(rv0[0]), .rsp0_ready_i(rr0), .rsp0_result_o(rres0[0]), .rsp0_err_o(re0[0]),
    .rsp1_valid_o(rv1[0]), .rsp1_ready_i(rr1), .rsp1_result_o(rres1[0]), .rsp1_err_o(re1[0]),
    .alu_op1_o(ao1[0]), .alu_op2_o(ao2[0]), .alu_aluop_o(aop[0]), .alu_result_i(ares[0])
  );

  alu_share_arb #(.FIXED_PRIO(1), .MAX_ALUOP(MAXOP)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_ready_o(rdy0[1]), .req0_op1_i(a0), .req0_op2_i(b0), .req0_aluop_i(op0),
    .req1_valid_i(v1), .req1_ready_o(rdy1[1]), .req1_op1_i(a1), .req1_op2_i(b1), .req1_aluop_i(op1),
    .rsp0_valid_o(rv0[1]), .rsp0_ready_i(rr0), .rsp0_result_o(rres0[1]), .rsp0_err_o(re0[1]),
    .rsp1_valid_o(rv1[1]), .rsp1_ready_i(rr1), .rsp1_result_o(rres1[1]), .rsp1_err_o(re1[1]),
    .alu_op1_o(ao1[1]), .alu_op2_o(ao2[1]), .alu_aluop_o(aop[1]), .alu_result_i(ares[1])
  );

  // Model state per instance k (0 = round robin, 1 = fixed) and slot n.
  bit          m_full [2][2];
  logic [31:0] m_res  [2][2];
  bit          m_err  [2][2];
  int          m_prio [2];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prio[k] = 0;
      for (int n = 0; n < 2; n++) begin
        m_full[k][n] = 1'b0;
        m_res[k][n]  = 32'd0;
        m_err[k][n]  = 1'b0;
      end
    end
  endtask

  // One cycle: starts at a negedge with inputs already driven, checks, advances the model at posedge.
  task automatic tick();
    int g [2];
    bit vv [2];
    bit rr [2];
    logic [31:0] xa [2];
    logic [31:0] xb [2];
    logic [5:0]  xo [2];
    vv = '{v0, v1};  rr = '{rr0, rr1};
    xa = '{a0, a1};  xb = '{b0, b1};  xo = '{op0, op1};
    #1;
    for (int k = 0; k < 2; k++) begin
      bit el [2];
      for (int n = 0; n < 2; n++) el[n] = rst_n && vv[n] && (!m_full[k][n] || rr[n]);
      g[k] = -1;
      if (el[0] && el[1]) g[k] = (k == 1) ? 0 : m_prio[k];
      else if (el[0]) g[k] = 0;
      else if (el[1]) g[k] = 1;
      chk("ready0", k, 32'(rdy0[k]), 32'(g[k] == 0));
      chk("ready1", k, 32'(rdy1[k]), 32'(g[k] == 1));
      chk("alu_op1", k, ao1[k], (g[k] < 0) ? 32'd0 : xa[g[k]]);
      chk("alu_op2", k, ao2[k], (g[k] < 0) ? 32'd0 : xb[g[k]]);
      chk("alu_aluop", k, 32'(aop[k]), (g[k] < 0) ? 32'd0 : 32'(xo[g[k]]));
      chk("rsp0_valid", k, 32'(rv0[k]), 32'(m_full[k][0]));
      chk("rsp1_valid", k, 32'(rv1[k]), 32'(m_full[k][1]));
      chk("rsp0_result", k, rres0[k], m_full[k][0] ? m_res[k][0] : 32'd0);
      chk("rsp1_result", k, rres1[k], m_full[k][1] ? m_res[k][1] : 32'd0);
      chk("rsp0_err", k, 32'(re0[k]), 32'(m_full[k][0] && m_err[k][0]));
      chk("rsp1_err", k, 32'(re1[k]), 32'(m_full[k][1] && m_err[k][1]));
    end
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int n = 0; n < 2; n++) begin
          if (g[k] == n) begin
            m_full[k][n] = 1'b1;
            m_err[k][n]  = (xo[n] > 6'(MAXOP));
            m_res[k][n]  = m_err[k][n] ? 32'd0 : alu_ref(xo[n], xa[n], xb[n]);
          end else if (m_full[k][n] && rr[n]) begin
            m_full[k][n] = 1'b0;
            m_res[k][n]  = 32'd0;
            m_err[k][n]  = 1'b0;
          end
        end
        if (g[k] >= 0) m_prio[k] = 1 - g[k];
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int seq [4];
    logic [31:0] held;
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0; op0 = 6'd0; op1 = 6'd0;
    model_reset();
    @(negedge clk);
    tick();
    v0 = 1'b1; v1 = 1'b1;
    tick();

    // Single requester ADD 5+7.
    rst_n = 1'b1; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    a0 = 32'd5; b0 = 32'd7; op0 = 6'd0;
    #1 chk("add_ready", 0, 32'(rdy0[0]), 32'd1);
    tick();
    v0 = 1'b0;
    #1;
    chk("add_valid", 0, 32'(rv0[0]), 32'd1);
    chk("add_result", 0, rres0[0], 32'd12);
    chk("add_err", 0, 32'(re0[0]), 32'd0);
    tick();

    // Contention right after a reset: round robin 0,1,0,1; fixed always 0.
    rst_n = 1'b0; model_reset();
    tick();
    rst_n = 1'b1;
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a0 = $urandom; b0 = $urandom; op0 = 6'($urandom_range(0, 9));
      a1 = $urandom; b1 = $urandom; op1 = 6'($urandom_range(0, 9));
      #1;
      seq[i] = rdy1[0] ? 1 : 0;
      chk("fixed_gnt0", 1, 32'(rdy0[1]), 32'd1);
      tick();
    end
    for (int i = 0; i < 4; i++) chk("rr_order", i, 32'(seq[i]), 32'(i % 2));

    // Backpressure on slot 1 (full from last grant); requester 0 keeps going.
    held = alu_ref(op1, a1, b1);
    rr1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a0 = $urandom; b0 = $urandom; op0 = 6'($urandom_range(0, 9));
      a1 = $urandom; b1 = $urandom;
      #1;
      chk("bp_ready1", 0, 32'(rdy1[0]), 32'd0);
      chk("bp_ready0", 0, 32'(rdy0[0]), 32'd1);
      chk("bp_held", 0, rres1[0], held);
      tick();
    end

    // Drain-and-refill with SUB 3-5.
    v1 = 1'b0; rr1 = 1'b1;
    a0 = 32'd3; b0 = 32'd5; op0 = 6'd1;
    #1 chk("refill_ready", 0, 32'(rdy0[0]), 32'd1);
    tick();
    op0 = 6'd12; a0 = 32'h1234_5678;
    #1 chk("sub_result", 0, rres0[0], 32'hFFFF_FFFE);
    tick();
    op0 = 6'd2; a0 = 32'hF0F0_F0F0; b0 = 32'h0FF0_0FF0;
    #1;
    chk("illegal_result", 0, rres0[0], 32'd0);
    chk("illegal_err", 0, 32'(re0[0]), 32'd1);
    tick();
    v0 = 1'b0;
    #1;
    chk("legal_err", 0, 32'(re0[0]), 32'd0);
    chk("legal_result", 0, rres0[0], 32'h00F0_00F0);
    tick();

    // Reset the cycle after a grant to requester 0 (pointer moved to 1).
    v0 = 1'b1; rr0 = 1'b0; a0 = 32'd1; b0 = 32'd1; op0 = 6'd0;
    tick();
    v0 = 1'b0;
    rst_n = 1'b0; model_reset();
    #1;
    chk("rst_valid0", 0, 32'(rv0[0]), 32'd0);
    chk("rst_result0", 0, rres0[0], 32'd0);
    tick();
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1;
    #1 chk("post_rst_gnt0", 0, 32'(rdy0[0]), 32'd1);
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      rr0 = ($urandom_range(0, 3) != 0); rr1 = ($urandom_range(0, 3) == 0);
      a0 = $urandom; b0 = $urandom; op0 = 6'($urandom_range(0, 15));
      a1 = $urandom; b1 = $urandom; op1 = 6'($urandom_range(0, 15));
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0; model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
